nes_pad_reader: RTL and testbench



---
 rtl/nes_pkg.sv | 25 ++
 rtl/nes_pad_reader_timer.sv | 35 +++
 rtl/nes_pad_reader.sv | 160 ++++++++++++++++
 tb/tb_nes_pad_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader.
// Button indices follow the order in which the pad shifts bits out.
package nes_pkg;

  localparam int NES_NUM_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETTLE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } nes_rd_state_t;

endpackage

// File: rtl/nes_pad_reader_timer.sv
// Phase timer: a down-counter reloaded to PHASE_CYC-1 on load.
// phase_last flags the final cycle of the current phase.
module nes_phase_timer #(
  parameter int PHASE_CYC = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic phase_last
);

  localparam int CW = (PHASE_CYC > 2) ? $clog2(PHASE_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(PHASE_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_last = (cnt_q == '0);

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller serial reader: generates latch/clock phases, shifts in the
// eight button bits and publishes them with valid/changed pulses.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int PHASE_CYC = 12,
  parameter int POLL_GAP  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [2:0] LAST_BIT = 3'(NES_NUM_BITS - 1);

  nes_rd_state_t state_q, state_d;
  logic          half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          pad_latch_q, pad_latch_d;
  logic          pad_clk_q, pad_clk_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic          busy_q, busy_d;
  logic          timer_load;
  logic          phase_last;

  nes_phase_timer #(
    .PHASE_CYC(PHASE_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .phase_last(phase_last)
  );

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    timer_load = 1'b0;

    // The gap counter idles at zero whenever auto-polling is off.
    gap_d = gap_q;
    if (!auto_en) begin
      gap_d = '0;
    end else if (state_q == ST_IDLE && gap_q != GW'(POLL_GAP)) begin
      gap_d = gap_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start || (auto_en && gap_d == GW'(POLL_GAP))) begin
          state_d    = ST_LATCH;
          half_d     = 1'b0;
          timer_load = 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_last) begin
          timer_load = 1'b1;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (phase_last) begin
          shift_d[0] = ~pad_data;
          bit_d      = 3'd1;
          state_d    = ST_CLK_LO;
          timer_load = 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (phase_last) begin
          state_d    = ST_CLK_HI;
          timer_load = 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (phase_last) begin
          shift_d[bit_q] = ~pad_data;
          timer_load     = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = ST_CLK_LO;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pin outputs follow the next state so they align with the state register.
    pad_latch_d = (state_d == ST_LATCH);
    pad_clk_d   = (state_d != ST_CLK_LO);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = (state_q == ST_DONE);
    changed_d   = (state_q == ST_DONE) && (shift_q != buttons_q);
    buttons_d   = (state_q == ST_DONE) ? shift_q : buttons_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      half_q      <= 1'b0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      gap_q       <= '0;
      buttons_q   <= 8'h00;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      gap_q       <= gap_d;
      buttons_q   <= buttons_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
      busy_q      <= busy_d;
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign changed   = changed_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader with P=2, POLL_GAP=5 and a
// behavioural pad shift register driving pad_data.
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, valid, changed, busy;
  logic [7:0] buttons;

  nes_pad_reader #(
    .PHASE_CYC(2),
    .POLL_GAP (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .auto_en  (auto_en),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .valid    (valid),
    .changed  (changed),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] btn;
    logic       chg;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Pad model plus monitor: one process so counts and checks never race.
  logic [7:0] pattern = 8'h00;
  logic [7:0] pad_sr = 8'h00;
  logic       pclk_prev = 1'b1;
  int         latch_cnt = 0;
  int         low_pulses = 0;
  int         low_len = 0;

  assign pad_data = ~pad_sr[0];

  always @(negedge clk) begin
    if (reset) begin
      latch_cnt  = 0;
      low_pulses = 0;
      low_len    = 0;
      pclk_prev  = 1'b1;
    end else begin
      if (pad_latch) begin
        pad_sr = pattern;
        latch_cnt++;
      end else if (pad_clk && !pclk_prev) begin
        pad_sr = {1'b0, pad_sr[7:1]};
        chk("clk_low_width", low_len, 2);
      end
      if (!pad_clk) begin
        if (pclk_prev) begin
          low_pulses++;
          low_len = 0;
        end
        low_len++;
      end
      pclk_prev = pad_clk;

      if (changed && !valid) chk("changed_without_valid", 1, 0);
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("buttons", int'(buttons), int'(e.btn));
          chk("changed", int'(changed), int'(e.chg));
          chk("valid_cycle", cyc, e.at);
          chk("latch_cycles", latch_cnt, 4);
          chk("clk_pulses", low_pulses, 7);
          $display("read: buttons=0x%02h changed=%0b cycle=%0d", buttons, changed, cyc);
        end
        latch_cnt  = 0;
        low_pulses = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    $display("reset check: %s", tag);
    chk("rst_pad_latch", int'(pad_latch), 0);
    chk("rst_pad_clk", int'(pad_clk), 1);
    chk("rst_buttons", int'(buttons), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_changed", int'(changed), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  // Issue one start; returns the cycle number of the edge that sampled it.
  task automatic pulse_start(output int n);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = cyc;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk({"timeout_", tag}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic do_read(input logic [7:0] pat, input logic exp_chg);
    int n;
    exp_t e;
    pattern = pat;
    pulse_start(n);
    e.btn = pat;
    e.chg = exp_chg;
    e.at  = n + 35;
    exp_q.push_back(e);
    wait_drain("read");
  endtask

  initial begin
    int   n;
    exp_t e;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("power-on");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    do_read(8'hA6, 1'b1);
    do_read(8'hA6, 1'b0);

    // Second start while busy must be ignored.
    pattern = 8'h3C;
    pulse_start(n);
    e.btn = 8'h3C; e.chg = 1'b1; e.at = n + 35;
    exp_q.push_back(e);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain("busy");
    repeat (40) @(posedge clk);
    chk("busy_start_queued", int'(busy), 0);

    // Reset at edge 20 of a read: no update, outputs back to reset values.
    pattern = 8'h81;
    pulse_start(n);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("mid-read");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    do_read(8'h81, 1'b1);

    do_read(8'hFF, 1'b1);
    do_read(8'h00, 1'b1);

    // Auto-poll: enabled after edge m, reads sampled at m+5, m+45, m+85.
    pattern = 8'h5A;
    @(posedge clk);
    #1 auto_en = 1'b1;
    n = cyc;
    e.btn = 8'h5A; e.chg = 1'b1; e.at = n + 40;  exp_q.push_back(e);
    e.btn = 8'h5A; e.chg = 1'b0; e.at = n + 80;  exp_q.push_back(e);
    e.btn = 8'h5A; e.chg = 1'b0; e.at = n + 120; exp_q.push_back(e);
    while (cyc < n + 90) @(posedge clk);
    #1 auto_en = 1'b0;
    wait_drain("auto");
    repeat (60) @(posedge clk);
    chk("auto_stopped_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
